// File: rtl/word_frame_pkg.sv
// Shared defaults and types for the word frame packer.
// Lane/frame geometry, counter width and FSM state encoding.
package word_frame_pkg;
  localparam int W  = 10;
  localparam int N  = 48;
  localparam int FW = W * N;
  localparam int IW = $clog2(N + 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

// File: rtl/frame_slot.sv
// Single register stage with valid/ready, generic payload.
// Ports: in_data/in_valid/in_ready upstream, out_* downstream.
module frame_slot
  import word_frame_pkg::*;
#(
  parameter int PW = FW + IW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [PW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  // Empty or draining this cycle: a new payload may land.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/word_frame_packer.sv
// Packs W-bit words into an N-lane frame with valid/ready output.
// Ports: in_data/in_valid/in_ready/in_flush, frame/frame_words/frame_valid/frame_ready.
module word_frame_packer
  import word_frame_pkg::*;
#(
  parameter int W = word_frame_pkg::W,
  parameter int N = word_frame_pkg::N
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [W-1:0]               in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_flush,
  output logic [W*N-1:0]             frame,
  output logic [$clog2(N+1)-1:0]     frame_words,
  output logic                       frame_valid,
  input  logic                       frame_ready
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = W * N;

  state_t        state;
  logic          rdy;
  logic [CW-1:0] idx;
  logic [CW-1:0] hcnt;
  logic [BW-1:0] pbuf;
  logic [BW-1:0] wbuf;
  logic [CW-1:0] pcnt;
  logic          acc;
  logic          close;
  logic          push;
  logic          slot_rdy;

  // in_ready comes straight from a flop, never from frame_ready.
  assign in_ready = rdy;

  always_comb begin
    acc   = in_valid && rdy;
    close = acc && (in_flush || idx == CW'(N - 1));
    wbuf  = pbuf;
    for (int k = 0; k < N; k++) begin
      if (acc && idx == CW'(k)) wbuf[k*W +: W] = in_data;
    end
    // In FULL nothing is accepted, so wbuf is the held frame.
    push = close || (state == FULL);
    pcnt = (state == FULL) ? hcnt : idx + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= FILL;
      rdy   <= 1'b0;
      idx   <= '0;
      hcnt  <= '0;
      pbuf  <= '0;
    end else begin
      unique case (state)
        FILL: begin
          rdy <= 1'b1;
          if (close) begin
            idx <= '0;
            if (slot_rdy) begin
              pbuf <= '0;
            end else begin
              pbuf  <= wbuf;
              hcnt  <= pcnt;
              state <= FULL;
              rdy   <= 1'b0;
            end
          end else if (acc) begin
            pbuf <= wbuf;
            idx  <= idx + CW'(1);
          end
        end
        FULL: begin
          if (slot_rdy) begin
            pbuf  <= '0;
            state <= FILL;
            rdy   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  frame_slot #(
    .PW(BW + CW)
  ) u_slot (
    .clk       (clk),
    .rstn      (rstn),
    .in_data   ({wbuf, pcnt}),
    .in_valid  (push),
    .in_ready  (slot_rdy),
    .out_data  ({frame, frame_words}),
    .out_valid (frame_valid),
    .out_ready (frame_ready)
  );

endmodule
